mpc_adc_frame_reader: RTL and testbench

Acquisition front end for the FCS-MPC controller. Periodically reads three channels (inductor current iL, grid voltage vg, capacitor voltage vc) from an external SPI-style serial ADC, and presents them as one coherent frame with a single-cycle valid strobe. It drives the serial pins and feeds the controller's iL/vg/vc inputs.

---
 rtl/mpc_io_pkg.sv | 19 +
 rtl/mpc_adc_spi_shifter.sv | 84 ++++++++
 rtl/mpc_adc_frame_reader.sv | 140 ++++++++++++++
 tb/tb_mpc_adc_frame_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mpc_io_pkg.sv
// Shared constants and types for the MPC acquisition front end.
// Channel numbering doubles as the 2-bit address sent to the ADC.
package mpc_io_pkg;

  localparam int ADC_DATA_W = 8;

  localparam logic [1:0] CH_IL = 2'd0;
  localparam logic [1:0] CH_VG = 2'd1;
  localparam logic [1:0] CH_VC = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mpc_adc_spi_shifter.sv
// One ADC conversion: a setup half-period with SCLK low, then 2+DATA_W SCLK periods
// shifting the channel address out and the result in. done flags the final cycle.
module mpc_adc_spi_shifter
  import mpc_io_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int SCLK_DIV = 2
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic [1:0]        addr,
  input  logic              sdo,
  output logic              sclk,
  output logic              mosi,
  output logic [DATA_W-1:0] data,
  output logic              done
);

  localparam int NHALF = 1 + 2 * (2 + DATA_W);
  localparam int HW    = $clog2(NHALF + 1);
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  logic              active_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [HW-1:0]     half_reg;
  logic [HW-1:0]     half_next;
  logic [1:0]        addr_reg;
  logic              sclk_reg;
  logic              mosi_reg;
  logic [DATA_W-1:0] data_reg;
  logic              half_end;

  // Half 0 is the setup phase; odd halves are SCLK low, even halves SCLK high.
  assign half_end  = active_reg && (div_reg == DIV_W'(SCLK_DIV - 1));
  assign half_next = half_reg + HW'(1);
  assign done      = half_end && (half_reg == HW'(NHALF - 1));

  always_ff @(posedge clk) begin
    if (srst) begin
      active_reg <= 1'b0;
      div_reg    <= '0;
      half_reg   <= '0;
      addr_reg   <= '0;
      sclk_reg   <= 1'b0;
      mosi_reg   <= 1'b0;
      data_reg   <= '0;
    end else if (start && !active_reg) begin
      active_reg <= 1'b1;
      div_reg    <= '0;
      half_reg   <= '0;
      addr_reg   <= addr;
      sclk_reg   <= 1'b0;
      mosi_reg   <= addr[1];
      data_reg   <= '0;
    end else if (active_reg) begin
      if (!half_end) begin
        div_reg <= div_reg + DIV_W'(1);
      end else begin
        div_reg <= '0;
        if (done) begin
          active_reg <= 1'b0;
          sclk_reg   <= 1'b0;
          mosi_reg   <= 1'b0;
        end else begin
          half_reg <= half_next;
          sclk_reg <= ~half_next[0];
          if (half_next[0]) begin
            mosi_reg <= (half_next == HW'(1)) ? addr_reg[1] :
                        (half_next == HW'(3)) ? addr_reg[0] : 1'b0;
          end else if (half_next >= HW'(6)) begin
            // Rising edge of a data period: the two address periods are skipped.
            data_reg <= {data_reg[DATA_W-2:0], sdo};
          end
        end
      end
    end
  end

  assign sclk = sclk_reg;
  assign mosi = mosi_reg;
  assign data = data_reg;

endmodule

// File: rtl/mpc_adc_frame_reader.sv
// Periodic three-channel ADC frame reader: period counter, channel sequencing,
// and frame registers that update all together on a single-cycle frame_valid.
module mpc_adc_frame_reader
  import mpc_io_pkg::*;
#(
  parameter int DATA_W        = ADC_DATA_W,
  parameter int SCLK_DIV      = 2,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              enable,
  input  logic              adc_sdo,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  output logic              adc_mosi,
  output logic [DATA_W-1:0] iL,
  output logic [DATA_W-1:0] vg,
  output logic [DATA_W-1:0] vc,
  output logic              frame_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DIV_W-1:0]  tmr_reg;
  logic [1:0]        ch_reg;
  logic              cs_n_reg;
  logic              busy_reg;
  logic              fv_reg;
  logic              ovr_reg;
  logic [DATA_W-1:0] il_reg, vg_reg, vc_reg;
  logic              tick, tmr_last, start;
  logic [1:0]        start_addr;
  logic              sh_done;
  logic [DATA_W-1:0] sh_data;

  assign tick       = enable && (cnt_reg == CNT_W'(SAMPLE_PERIOD - 1));
  assign tmr_last   = (tmr_reg == DIV_W'(SCLK_DIV - 1));
  assign start      = ((state_reg == IDLE) && tick) ||
                      ((state_reg == GAP) && tmr_last && (ch_reg != CH_VC));
  assign start_addr = (state_reg == IDLE) ? CH_IL : ch_reg + 2'd1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !enable) cnt_reg <= '0;
    else if (tick)           cnt_reg <= '0;
    else                     cnt_reg <= cnt_reg + CNT_W'(1);
  end

  mpc_adc_spi_shifter #(.DATA_W(DATA_W), .SCLK_DIV(SCLK_DIV)) u_shifter (
    .clk  (wb_clk_i),
    .srst (wb_rst_i),
    .start(start),
    .addr (start_addr),
    .sdo  (adc_sdo),
    .sclk (adc_sclk),
    .mosi (adc_mosi),
    .data (sh_data),
    .done (sh_done)
  );

  // Per-channel capture staging so partial frames never reach the outputs.
  for (genvar gi = 0; gi < 3; gi++) begin : gen_cap
    logic [DATA_W-1:0] val_reg;
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) val_reg <= '0;
      else if ((state_reg == SHIFT) && sh_done && (ch_reg == 2'(gi))) val_reg <= sh_data;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= IDLE;
      tmr_reg   <= '0;
      ch_reg    <= CH_IL;
      cs_n_reg  <= 1'b1;
      busy_reg  <= 1'b0;
      fv_reg    <= 1'b0;
      ovr_reg   <= 1'b0;
      il_reg    <= '0;
      vg_reg    <= '0;
      vc_reg    <= '0;
    end else begin
      fv_reg  <= 1'b0;
      ovr_reg <= tick && (state_reg != IDLE);
      case (state_reg)
        IDLE: if (tick) begin
          state_reg <= SETUP;
          ch_reg    <= CH_IL;
          tmr_reg   <= '0;
          cs_n_reg  <= 1'b0;
          busy_reg  <= 1'b1;
        end
        SETUP: begin
          if (tmr_last) state_reg <= SHIFT;
          else          tmr_reg   <= tmr_reg + DIV_W'(1);
        end
        SHIFT: if (sh_done) begin
          state_reg <= GAP;
          tmr_reg   <= '0;
          cs_n_reg  <= 1'b1;
        end
        GAP: begin
          if (!tmr_last) begin
            tmr_reg <= tmr_reg + DIV_W'(1);
          end else if (ch_reg != CH_VC) begin
            state_reg <= SETUP;
            ch_reg    <= ch_reg + 2'd1;
            tmr_reg   <= '0;
            cs_n_reg  <= 1'b0;
          end else begin
            state_reg <= DONE;
            fv_reg    <= 1'b1;
            il_reg    <= gen_cap[0].val_reg;
            vg_reg    <= gen_cap[1].val_reg;
            vc_reg    <= gen_cap[2].val_reg;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign adc_cs_n    = cs_n_reg;
  assign busy        = busy_reg;
  assign frame_valid = fv_reg;
  assign overrun     = ovr_reg;
  assign iL          = il_reg;
  assign vg          = vg_reg;
  assign vc          = vc_reg;

endmodule

// File: tb/tb_mpc_adc_frame_reader.sv
// Directed bench: three reader instances (default, short period, SCLK_DIV=3), each
// served by a behavioural ADC that answers from the address it receives.
module tb_mpc_adc_frame_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst = 3'b111;
  logic [2:0]      en  = 3'b000;
  logic [2:0]      cs_n, sclk, mosi, fv, busy, ovr;
  logic [2:0][7:0] il, vg, vc;
  logic [7:0]      val [3][4];

  int checks = 0;
  int errors = 0;

  for (genvar gi = 0; gi < 3; gi++) begin : gen_inst
    logic sdo_b = 1'b0;
    logic [1:0] a = 2'd0;
    logic [1:0] alog[$];
    logic [7:0] w;
    int k = 0;
    logic sp = 1'b0, cp = 1'b1;
    int run = 0, hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0, viol = 0;
    logic ps = 1'b0, pm = 1'b0, seen = 1'b0;

    mpc_adc_frame_reader #(
      .DATA_W(8), .SCLK_DIV((gi == 2) ? 3 : 2), .SAMPLE_PERIOD((gi == 1) ? 100 : 200)
    ) dut (
      .wb_clk_i(clk), .wb_rst_i(rst[gi]), .enable(en[gi]), .adc_sdo(sdo_b),
      .adc_cs_n(cs_n[gi]), .adc_sclk(sclk[gi]), .adc_mosi(mosi[gi]),
      .iL(il[gi]), .vg(vg[gi]), .vc(vc[gi]),
      .frame_valid(fv[gi]), .busy(busy[gi]), .overrun(ovr[gi])
    );

    // ADC model: address captured on SCLK rise, data changes after SCLK fall.
    always @(sclk[gi] or cs_n[gi]) begin
      if (cp === 1'b1 && cs_n[gi] === 1'b0) begin
        k = 0; a = 2'd0; sdo_b = 1'b0;
      end else if (sp === 1'b0 && sclk[gi] === 1'b1) begin
        if (k < 2) a = {a[0], mosi[gi]};
        if (k == 1) alog.push_back(a);
      end else if (sp === 1'b1 && sclk[gi] === 1'b0) begin
        k = k + 1;
        w = val[gi][a];
        sdo_b = (k >= 2 && k <= 9) ? w[9-k] : 1'b0;
      end
      sp = sclk[gi];
      cp = cs_n[gi];
    end

    always @(negedge clk) begin
      if (sclk[gi] !== ps) begin
        if (ps === 1'b1) begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
        end else if (seen) begin
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end
        run = 0;
      end
      if (cs_n[gi] !== 1'b0) seen = 1'b0;
      else if (sclk[gi] === 1'b1) seen = 1'b1;
      if (sclk[gi] === 1'b1 && mosi[gi] !== pm) viol++;
      run++;
      ps = sclk[gi];
      pm = mosi[gi];
    end
  end

  // Waits for a cs_n falling edge (on_cs=1) or a frame_valid sample; n = cycles waited.
  task automatic wait_evt(input int inst, input bit on_cs, input int max_cyc,
                          output int n, output bit ok);
    logic prev;
    ok = 1'b0; n = 0; prev = cs_n[inst];
    while (n < max_cyc && !ok) begin
      @(negedge clk);
      n++;
      if (on_cs ? (prev === 1'b1 && cs_n[inst] === 1'b0) : (fv[inst] === 1'b1)) ok = 1'b1;
      prev = cs_n[inst];
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (cs_n !== 3'b111) begin errors++; $display("FAIL reset_cs_n got %b want 111", cs_n); end
    checks++; if (sclk !== 3'b000 || mosi !== 3'b000) begin errors++; $display("FAIL reset_sclk_mosi got %b/%b want 000/000", sclk, mosi); end
    checks++; if (fv !== 3'b000 || busy !== 3'b000 || ovr !== 3'b000) begin errors++; $display("FAIL reset_flags got %b/%b/%b want 0", fv, busy, ovr); end
    checks++; if (il !== '0 || vg !== '0 || vc !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h want 0", il, vg, vc); end
    $display("reset: cs_n=%b sclk=%b busy=%b", cs_n, sclk, busy);
    rst = 3'b000;
  endtask

  task automatic test_basic_frame();
    int n; bit ok;
    val[0][0] = 8'hA5; val[0][1] = 8'h3C; val[0][2] = 8'hF0; val[0][3] = 8'h00;
    en[0] = 1'b1;
    wait_evt(0, 1'b1, 400, n, ok);
    checks++; if (!ok || busy[0] !== 1'b1) begin errors++; $display("FAIL basic_start ok=%0d busy=%b want 1/1", ok, busy[0]); end
    wait_evt(0, 1'b0, 300, n, ok);
    checks++; if (!ok || n != 132) begin errors++; $display("FAIL basic_latency got %0d want 132 after cs fall", n); end
    checks++; if (il[0] !== 8'hA5 || vg[0] !== 8'h3C || vc[0] !== 8'hF0) begin errors++; $display("FAIL basic_data got %h/%h/%h want a5/3c/f0", il[0], vg[0], vc[0]); end
    checks++; if (gen_inst[0].alog.size() != 3 || gen_inst[0].alog[0] !== 2'd0 || gen_inst[0].alog[1] !== 2'd1 || gen_inst[0].alog[2] !== 2'd2) begin
      errors++; $display("FAIL basic_addr got size %0d want 00,01,10", gen_inst[0].alog.size()); end
    $display("frame inst0: iL=%h vg=%h vc=%h latency=%0d", il[0], vg[0], vc[0], n + 1);
    @(negedge clk);
    checks++; if (fv[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL basic_pulse fv=%b busy=%b want 0/0", fv[0], busy[0]); end
  endtask

  task automatic test_coherence();
    int n = 1, bad = 0; bit got = 1'b0; logic prev;
    prev = cs_n[0];
    while (n < 400 && !got) begin
      @(negedge clk); n++;
      if (prev === 1'b1 && cs_n[0] === 1'b0) begin
        val[0][0] = 8'h01; val[0][1] = 8'h02; val[0][2] = 8'h03;
      end
      prev = cs_n[0];
      if (fv[0] === 1'b1) got = 1'b1;
      else if ({il[0], vg[0], vc[0]} !== 24'hA53CF0) bad++;
    end
    checks++; if (!got || n != 200) begin errors++; $display("FAIL coh_spacing got %0d want 200", n); end
    checks++; if (bad != 0) begin errors++; $display("FAIL coh_hold got %0d changed cycles want 0", bad); end
    checks++; if (il[0] !== 8'h01 || vg[0] !== 8'h02 || vc[0] !== 8'h03) begin errors++; $display("FAIL coh_data got %h/%h/%h want 01/02/03", il[0], vg[0], vc[0]); end
    $display("frame inst0: iL=%h vg=%h vc=%h spacing=%0d", il[0], vg[0], vc[0], n);
    en[0] = 1'b0;
  endtask

  task automatic test_overrun();
    int n, nfv = 0, novr = 0, last = -1, sp_bad = 0, dbad = 0; bit ok;
    val[1][0] = 8'h11; val[1][1] = 8'h22; val[1][2] = 8'h33; val[1][3] = 8'h00;
    en[1] = 1'b1;
    wait_evt(1, 1'b1, 300, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_start got timeout want cs fall"); end
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (ovr[1] === 1'b1) novr++;
      if (fv[1] === 1'b1) begin
        nfv++;
        if (last >= 0 && c - last != 200) sp_bad++;
        last = c;
        if (il[1] !== 8'h11 || vg[1] !== 8'h22 || vc[1] !== 8'h33) dbad++;
        $display("frame inst1: iL=%h vg=%h vc=%h at %0d", il[1], vg[1], vc[1], c);
      end
    end
    checks++; if (novr != 3) begin errors++; $display("FAIL ovr_count got %0d want 3", novr); end
    checks++; if (nfv != 3 || sp_bad != 0) begin errors++; $display("FAIL ovr_frames got %0d frames %0d bad gaps want 3/0", nfv, sp_bad); end
    checks++; if (dbad != 0) begin errors++; $display("FAIL ovr_data got %0d bad frames want 0", dbad); end
    en[1] = 1'b0;
  endtask

  task automatic test_enable_drop();
    int n; bit ok;
    val[0][0] = 8'h5A; val[0][1] = 8'hC3; val[0][2] = 8'h0F;
    en[0] = 1'b1;
    wait_evt(0, 1'b1, 400, n, ok);
    repeat (59) @(negedge clk);
    en[0] = 1'b0;
    wait_evt(0, 1'b0, 200, n, ok);
    checks++; if (!ok || n != 73) begin errors++; $display("FAIL drop_latency got %0d want 73", n); end
    checks++; if (il[0] !== 8'h5A || vg[0] !== 8'hC3 || vc[0] !== 8'h0F) begin errors++; $display("FAIL drop_data got %h/%h/%h want 5a/c3/0f", il[0], vg[0], vc[0]); end
    $display("frame inst0: iL=%h vg=%h vc=%h after enable drop", il[0], vg[0], vc[0]);
    wait_evt(0, 1'b1, 300, n, ok);
    checks++; if (ok || busy[0] !== 1'b0) begin errors++; $display("FAIL drop_idle got cs_fall=%0d busy=%b want 0/0", ok, busy[0]); end
  endtask

  task automatic test_spi_timing();
    int n; bit ok;
    val[2][0] = 8'h96; val[2][1] = 8'h69; val[2][2] = 8'hC7; val[2][3] = 8'h00;
    en[2] = 1'b1;
    wait_evt(2, 1'b1, 400, n, ok);
    wait_evt(2, 1'b0, 300, n, ok);
    checks++; if (!ok || n != 198) begin errors++; $display("FAIL spi_latency got %0d want 198 after cs fall", n); end
    checks++; if (il[2] !== 8'h96 || vg[2] !== 8'h69 || vc[2] !== 8'hC7) begin errors++; $display("FAIL spi_data got %h/%h/%h want 96/69/c7", il[2], vg[2], vc[2]); end
    checks++; if (gen_inst[2].hi_min != 3 || gen_inst[2].hi_max != 3 || gen_inst[2].lo_min != 3 || gen_inst[2].lo_max != 3) begin
      errors++; $display("FAIL spi_phase3 got hi %0d..%0d lo %0d..%0d want 3", gen_inst[2].hi_min, gen_inst[2].hi_max, gen_inst[2].lo_min, gen_inst[2].lo_max); end
    checks++; if (gen_inst[0].hi_min != 2 || gen_inst[0].hi_max != 2 || gen_inst[0].lo_min != 2 || gen_inst[0].lo_max != 2) begin
      errors++; $display("FAIL spi_phase2 got hi %0d..%0d lo %0d..%0d want 2", gen_inst[0].hi_min, gen_inst[0].hi_max, gen_inst[0].lo_min, gen_inst[0].lo_max); end
    checks++; if (gen_inst[2].viol != 0 || gen_inst[0].viol != 0) begin errors++; $display("FAIL spi_mosi_stable got %0d/%0d changes while high want 0", gen_inst[2].viol, gen_inst[0].viol); end
    $display("frame inst2: iL=%h vg=%h vc=%h latency=%0d", il[2], vg[2], vc[2], n + 1);
    en[2] = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int n, nfv = 0; bit ok;
    en[0] = 1'b1;
    wait_evt(0, 1'b1, 400, n, ok);
    repeat (29) @(negedge clk);
    checks++; if (busy[0] !== 1'b1 || cs_n[0] !== 1'b0) begin errors++; $display("FAIL rst_pre got busy=%b cs_n=%b want 1/0", busy[0], cs_n[0]); end
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    checks++; if (cs_n[0] !== 1'b1 || sclk[0] !== 1'b0 || busy[0] !== 1'b0 || fv[0] !== 1'b0) begin
      errors++; $display("FAIL rst_pins got cs_n=%b sclk=%b busy=%b fv=%b want 1/0/0/0", cs_n[0], sclk[0], busy[0], fv[0]); end
    checks++; if (il[0] !== 8'h00 || vg[0] !== 8'h00 || vc[0] !== 8'h00) begin errors++; $display("FAIL rst_data got %h/%h/%h want 0", il[0], vg[0], vc[0]); end
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (fv[0] === 1'b1) nfv++;
    end
    checks++; if (nfv != 0) begin errors++; $display("FAIL rst_no_frame got %0d pulses want 0", nfv); end
    $display("reset mid-shift: cs_n=%b busy=%b frames=%0d", cs_n[0], busy[0], nfv);
    en[0] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) for (int j = 0; j < 4; j++) val[i][j] = 8'h00;
    test_reset();
    test_basic_frame();
    test_coherence();
    test_overrun();
    test_enable_drop();
    test_spi_timing();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
